free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 107 ++++++++++
 tb/tb_free_list.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical register free list: circular tag buffer with flush recovery.
// Define FREE_LIST_BYPASS_EN to hand a returning tag straight to dispatch when empty.
module free_list #(
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32,
    localparam int N  = PHYS_REG_SZ - ARCH_REG_SZ,
    localparam int TW = $clog2(PHYS_REG_SZ),
    localparam int CW = $clog2(N) + 1,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          alloc_req,
    output logic          alloc_valid,
    output logic [TW-1:0] alloc_tag,
    input  logic          retire_en,
    input  logic          retire_has_dest,
    input  logic [TW-1:0] retire_tag,
    output logic [CW-1:0] free_count,
    output logic          overflow_err
);

    logic [TW-1:0] tags_q [N];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] rhead_q, rhead_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wr_en;
    logic          ret;
    logic          full;
    logic          empty;
    logic          byp;
    logic          alloc_fire;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ret   = retire_en && retire_has_dest;
    assign full  = (count_q == CW'(N));
    assign empty = (count_q == '0);

`ifdef FREE_LIST_BYPASS_EN
    assign byp = empty && ret && !flush;
`else
    assign byp = 1'b0;
`endif

    assign alloc_valid = (!empty || byp) && !flush;
    assign alloc_tag   = byp ? retire_tag : tags_q[head_q];
    assign alloc_fire  = alloc_req && alloc_valid;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        rhead_d = rhead_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        if (ret && full) begin
            ovf_d = 1'b1;
        end else if (ret && byp && alloc_req) begin
            // Tag goes straight to dispatch: only the architectural point moves
            rhead_d = inc(rhead_q);
        end else if (ret) begin
            wr_en   = 1'b1;
            tail_d  = inc(tail_q);
            rhead_d = inc(rhead_q);
            count_d = count_q + CW'(1);
        end
        if (flush) begin
            head_d  = rhead_d;
            count_d = CW'(N);
        end else if (alloc_fire && !byp) begin
            head_d  = inc(head_q);
            count_d = count_d - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                tags_q[i] <= TW'(ARCH_REG_SZ + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            rhead_q <= '0;
            count_q <= CW'(N);
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                tags_q[tail_q] <= retire_tag;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            rhead_q <= rhead_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign free_count   = count_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: alloc order, return, flush, overflow, wrap.
// Scoreboard section checks no tag is duplicated or lost across wrap.
module tb_free_list;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       retire_en;
    logic       retire_has_dest;
    logic [5:0] retire_tag;
    logic [5:0] free_count;
    logic       overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    free_list dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_tag       (alloc_tag),
        .retire_en       (retire_en),
        .retire_has_dest (retire_has_dest),
        .retire_tag      (retire_tag),
        .free_count      (free_count),
        .overflow_err    (overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        flush           = 1'b0;
        alloc_req       = 1'b0;
        retire_en       = 1'b0;
        retire_has_dest = 1'b0;
        retire_tag      = '0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        alloc_req = 1'b1;
        for (int i = 0; i < n; i++) tick();
        alloc_req = 1'b0;
    endtask

    task automatic retire(input int t);
        retire_en       = 1'b1;
        retire_has_dest = 1'b1;
        retire_tag      = 6'(t);
    endtask

    int q[$];
    int outq[$];
    bit seen[64];
    int e;
    int t;

    initial begin
        clear_in();
        reset = 1'b0;
        do_reset();

        #1;
        chk("rst_count", free_count, 32);
        chk("rst_valid", alloc_valid, 1);
        chk("rst_tag", alloc_tag, 32);
        chk("rst_ovf", overflow_err, 0);

        // 32 back-to-back allocations
        alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("seq_tag", alloc_tag, 32 + i);
            chk("seq_valid", alloc_valid, 1);
            tick();
        end
        #1;
        chk("empty_valid", alloc_valid, 0);
        chk("empty_count", free_count, 0);
        alloc_req = 1'b0;

`ifdef FREE_LIST_BYPASS_EN
        retire(5);
        alloc_req = 1'b1;
        #1;
        chk("byp_valid", alloc_valid, 1);
        chk("byp_tag", alloc_tag, 5);
        tick();
        clear_in();
        #1;
        chk("byp_count", free_count, 0);
        chk("byp_after_valid", alloc_valid, 0);
`endif
        retire(5);
        #1;
`ifndef FREE_LIST_BYPASS_EN
        chk("ret_same_valid", alloc_valid, 0);
`endif
        tick();
        clear_in();
        #1;
        chk("ret_tag", alloc_tag, 5);
        chk("ret_valid", alloc_valid, 1);
        chk("ret_count", free_count, 1);

        // simultaneous alloc and return at count 10
        do_reset();
        alloc_n(22);
        #1;
        chk("c10_count", free_count, 10);
        alloc_req = 1'b1;
        retire(7);
        #1;
        chk("c10_tag", alloc_tag, 54);
        tick();
        clear_in();
        #1;
        chk("c10_count_hold", free_count, 10);
        chk("c10_head", alloc_tag, 55);
        alloc_n(9);
        #1;
        chk("c10_wrap_tag", alloc_tag, 7);
        chk("c10_wrap_count", free_count, 1);
        alloc_n(1);
        retire(9);
        tick();
        clear_in();
        #1;
        chk("c10_tail", alloc_tag, 9);

        // flush recovery
        do_reset();
        alloc_n(4);
        retire(3);
        tick();
        clear_in();
        flush     = 1'b1;
        alloc_req = 1'b1;
        #1;
        chk("fl_valid", alloc_valid, 0);
        tick();
        clear_in();
        #1;
        chk("fl_count", free_count, 32);
        chk("fl_tag", alloc_tag, 33);

        // overflow on full list
        do_reset();
        retire(9);
        tick();
        clear_in();
        #1;
        chk("ovf_set", overflow_err, 1);
        chk("ovf_count", free_count, 32);
        chk("ovf_head", alloc_tag, 32);
        alloc_n(1);
        #1;
        chk("ovf_sticky", overflow_err, 1);
        chk("ovf_count2", free_count, 31);
        retire(12);
        tick();
        clear_in();
        alloc_n(31);
        #1;
        chk("ovf_tail", alloc_tag, 12);

        // reset wins over every other input
        reset           = 1'b1;
        flush           = 1'b1;
        alloc_req       = 1'b1;
        retire_en       = 1'b1;
        retire_has_dest = 1'b1;
        retire_tag      = 6'd1;
        tick();
        reset = 1'b0;
        clear_in();
        #1;
        chk("rst2_ovf", overflow_err, 0);
        chk("rst2_count", free_count, 32);
        chk("rst2_tag", alloc_tag, 32);

        // has_dest low is ignored
        retire_en  = 1'b1;
        retire_tag = 6'd4;
        tick();
        clear_in();
        #1;
        chk("nodest_ovf", overflow_err, 0);
        chk("nodest_count", free_count, 32);

        // scoreboard across pointer wrap
        for (int i = 32; i < 64; i++) q.push_back(i);
        for (int i = 0; i < 40; i++) begin
            alloc_req = 1'b1;
            #1;
            e = q.pop_front();
            chk("sb_alloc", alloc_tag, e);
            outq.push_back(e);
            tick();
            alloc_req = 1'b0;
            t = outq.pop_front();
            retire(t);
            tick();
            clear_in();
            q.push_back(t);
        end
        #1;
        chk("sb_count", free_count, 32);
        for (int i = 0; i < 32; i++) begin
            #1;
            t = int'(alloc_tag);
            e = q.pop_front();
            chk("sb_drain", t, e);
            chk("sb_dup", int'(seen[t]), 0);
            seen[t] = 1'b1;
            alloc_n(1);
        end
        #1;
        chk("sb_empty", free_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
